// File: rtl/axi_sram.sv
// AXI4 slave SRAM: one burst in service at a time, 64-bit data path,
// byte-strobed writes and FIXED/INCR/WRAP address sequencing.
package axi_sram_pkg;
   localparam int CFG_SYSBUS_ADDR_BITS = 48;
   localparam int CFG_ID_BITS = 5;
   localparam int CFG_USER_BITS = 1;

   localparam logic [15:0] VENDOR_OPTIMITECH = 16'h00F1;
   localparam logic [15:0] OPTIMITECH_SRAM = 16'h0073;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [63:0] addr_start;
      logic [63:0] addr_end;
   } mapinfo_type;

   typedef struct packed {
      logic [15:0] vid;
      logic [15:0] did;
      logic [63:0] addr_start;
      logic [63:0] addr_end;
   } dev_config_type;

   typedef struct packed {
      logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
   } axi4_metadata_type;

   typedef struct packed {
      logic aw_valid;
      axi4_metadata_type aw_bits;
      logic [CFG_ID_BITS-1:0] aw_id;
      logic [CFG_USER_BITS-1:0] aw_user;
      logic w_valid;
      logic [63:0] w_data;
      logic w_last;
      logic [7:0] w_strb;
      logic [CFG_USER_BITS-1:0] w_user;
      logic b_ready;
      logic ar_valid;
      axi4_metadata_type ar_bits;
      logic [CFG_ID_BITS-1:0] ar_id;
      logic [CFG_USER_BITS-1:0] ar_user;
      logic r_ready;
   } axi4_slave_in_type;

   typedef struct packed {
      logic aw_ready;
      logic w_ready;
      logic b_valid;
      logic [1:0] b_resp;
      logic [CFG_ID_BITS-1:0] b_id;
      logic [CFG_USER_BITS-1:0] b_user;
      logic ar_ready;
      logic r_valid;
      logic [1:0] r_resp;
      logic [63:0] r_data;
      logic r_last;
      logic [CFG_ID_BITS-1:0] r_id;
      logic [CFG_USER_BITS-1:0] r_user;
   } axi4_slave_out_type;
endpackage

module axi_sram
   import axi_sram_pkg::*;
#(
   parameter int async_reset = 1,
   parameter int abits = 16,
   parameter logic [15:0] did = OPTIMITECH_SRAM
)(
   input  logic i_clk,
   input  logic i_nrst,
   input  mapinfo_type i_mapinfo,
   output dev_config_type o_cfg,
   input  axi4_slave_in_type i_xslvi,
   output axi4_slave_out_type o_xslvo
);

   localparam int WORDS = 1 << (abits - 3);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WDATA, WRESP} state_e;

   typedef struct packed {
      state_e state;
      logic [abits-1:0] addr;
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
      logic [CFG_ID_BITS-1:0] id;
      logic [CFG_USER_BITS-1:0] user;
      logic [7:0] cnt;
   } regs_t;

   localparam regs_t R_RESET = '{state: IDLE, addr: '0, len: '0, size: '0,
                                 burst: '0, id: '0, user: '0, cnt: '0};

   regs_t r, rin;
   logic [63:0] mem [0:WORDS-1];
   logic [63:0] rdata;
   logic we;
   logic unused_in;

   // WRAP keeps the low bits inside a (len+1)<<size window; all arithmetic wraps at 2^abits.
   function automatic logic [abits-1:0] next_addr(input logic [abits-1:0] a,
                                                  input logic [7:0] len,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
      logic [abits-1:0] incr;
      logic [abits-1:0] mask;
      incr = a + (abits'(1) << size);
      mask = ((abits'(len) + abits'(1)) << size) - abits'(1);
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~mask) | (incr & mask);
         default: return incr;
      endcase
   endfunction

   assign o_cfg = '{vid: VENDOR_OPTIMITECH, did: did,
                    addr_start: i_mapinfo.addr_start, addr_end: i_mapinfo.addr_end};

   assign unused_in = ^{i_xslvi.aw_bits.addr[CFG_SYSBUS_ADDR_BITS-1:abits],
                        i_xslvi.ar_bits.addr[CFG_SYSBUS_ADDR_BITS-1:abits],
                        i_xslvi.aw_user, i_xslvi.w_user};

   always_comb begin
      rin = r;
      case (r.state)
         IDLE: begin
            if (i_xslvi.aw_valid) begin
               rin.state = WDATA;
               rin.addr = i_xslvi.aw_bits.addr[abits-1:0];
               rin.len = i_xslvi.aw_bits.len;
               rin.size = i_xslvi.aw_bits.size;
               rin.burst = i_xslvi.aw_bits.burst;
               rin.id = i_xslvi.aw_id;
               rin.cnt = '0;
            end else if (i_xslvi.ar_valid) begin
               rin.state = RADDR;
               rin.addr = i_xslvi.ar_bits.addr[abits-1:0];
               rin.len = i_xslvi.ar_bits.len;
               rin.size = i_xslvi.ar_bits.size;
               rin.burst = i_xslvi.ar_bits.burst;
               rin.id = i_xslvi.ar_id;
               rin.user = i_xslvi.ar_user;
               rin.cnt = '0;
            end
         end
         RADDR: rin.state = RDATA;
         RDATA: begin
            if (i_xslvi.r_ready) begin
               if (r.cnt == r.len) begin
                  rin.state = IDLE;
               end else begin
                  rin.addr = next_addr(r.addr, r.len, r.size, r.burst);
                  rin.cnt = r.cnt + 8'd1;
                  rin.state = RADDR;
               end
            end
         end
         WDATA: begin
            if (i_xslvi.w_valid) begin
               rin.addr = next_addr(r.addr, r.len, r.size, r.burst);
               rin.cnt = r.cnt + 8'd1;
               if (i_xslvi.w_last) begin
                  rin.state = WRESP;
               end
            end
         end
         WRESP: begin
            if (i_xslvi.b_ready) begin
               rin.state = IDLE;
            end
         end
         default: rin.state = IDLE;
      endcase
      if ((async_reset == 0) && !i_nrst) begin
         rin = R_RESET;
      end
   end

   // Handshake outputs are masked while reset is low so nothing leaks out during reset.
   always_comb begin
      o_xslvo = '0;
      o_xslvo.aw_ready = i_nrst && (r.state == IDLE);
      o_xslvo.ar_ready = i_nrst && (r.state == IDLE) && !i_xslvi.aw_valid;
      o_xslvo.w_ready = i_nrst && (r.state == WDATA);
      o_xslvo.b_valid = i_nrst && (r.state == WRESP);
      o_xslvo.b_resp = (r.cnt == r.len + 8'd1) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      o_xslvo.b_id = r.id;
      o_xslvo.r_valid = i_nrst && (r.state == RDATA);
      o_xslvo.r_resp = AXI_RESP_OKAY;
      o_xslvo.r_data = rdata;
      o_xslvo.r_last = (r.cnt == r.len);
      o_xslvo.r_id = r.id;
      o_xslvo.r_user = r.user;
   end

   generate
      if (async_reset != 0) begin : g_async
         always_ff @(posedge i_clk or negedge i_nrst) begin
            if (!i_nrst) begin
               r <= R_RESET;
            end else begin
               r <= rin;
            end
         end
      end else begin : g_sync
         always_ff @(posedge i_clk) begin
            r <= rin;
         end
      end
   endgenerate

   assign we = i_nrst && (r.state == WDATA) && i_xslvi.w_valid;

   // Storage and read register carry no reset; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (i_xslvi.w_strb[i]) begin
               mem[r.addr[abits-1:3]][8*i +: 8] <= i_xslvi.w_data[8*i +: 8];
            end
         end
      end
      if (r.state == RADDR) begin
         rdata <= mem[r.addr[abits-1:3]];
      end
   end

endmodule

// File: doc/axi_sram.md
AXI_SRAM -- requirements
Module: axi_sram

Interface
REQ-001 SHALL have parameter async_reset, default 1, meaning 1=async reset flops, 0=sync reset via i_nrst sampled in comb logic.
REQ-002 SHALL have parameter abits, default 16, meaning memory size 2^abits bytes, byte-addressed.
REQ-003 SHALL have parameter did, default OPTIMITECH_SRAM, meaning device id reported in o_cfg.
REQ-004 SHALL have port i_clk  input  1  system clock; all state is updated on the rising edge.
REQ-005 SHALL have port i_nrst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port i_mapinfo  input  mapinfo_type  address window assigned by bus0 interconnect.
REQ-007 SHALL have port o_cfg  output  dev_config_type  device descriptor.
REQ-008 SHALL have port i_xslvi  input  axi4_slave_in_type  AXI4 request channels from interconnect.
REQ-009 SHALL have port o_xslvo  output  axi4_slave_out_type  AXI4 response channels to interconnect.

Function
REQ-010 SHALL hold o_cfg constant: vid=VENDOR_OPTIMITECH, did=did, address fields copied from i_mapinfo.
REQ-011 SHALL implement FSM states IDLE, RADDR, RDATA, WDATA, WRESP; exactly one burst is in service at a time.
REQ-012 SHALL drive aw_ready=1 only in IDLE, and ar_ready=1 only in IDLE with aw_valid=0. Write has priority when both are valid.
REQ-013 SHALL on AR handshake capture addr[abits-1:0], len, size, burst, ar_id and ar_user; clear the beat counter; go to RADDR.
REQ-014 SHALL in RADDR read the 64-bit word at addr[abits-1:3] into the r_data register; go to RDATA.
REQ-015 SHALL in RDATA drive r_valid=1, r_resp=OKAY(00), r_id/r_user=captured values, r_last=(beat counter==len).
REQ-016 SHALL on r_valid&r_ready in RDATA behave as follows:
- if r_last: go to IDLE;
- else: advance the address per REQ-020, increment the beat counter, go to RADDR.
REQ-017 SHALL hold r_data, r_last and r_id stable while r_ready=0. First r_valid is 2 cycles after AR handshake; throughput is 1 beat / 2 cycles.
REQ-018 SHALL on AW handshake capture addr, len, size, burst and aw_id; go to WDATA.
REQ-019 SHALL in WDATA drive w_ready=1. On each w_valid beat:
- write bytes of w_data enabled by w_strb[i] at addr[abits-1:3];
- advance the address and the beat counter;
- on w_last, go to WRESP.
REQ-020 SHALL advance the address as follows; the address always wraps modulo 2^abits:
- FIXED(00): unchanged;
- INCR(01) and reserved(11): +(1<<size);
- WRAP(10): +(1<<size) within a boundary of (len+1)*(1<<size) aligned to that size.
REQ-021 SHALL in WRESP drive b_valid=1 and b_id=captured aw_id. b_resp SHALL be OKAY if the number of beats received equals len+1, else SLVERR(10). On b_ready go to IDLE.
REQ-022 SHALL ignore w_valid outside WDATA (w_ready=0) and r_ready/b_ready when the matching valid is 0.
REQ-023 SHALL keep the beat counter 8 bits wide; len=255 gives 256 beats with no overflow error.
REQ-024 SHALL respond OKAY to every address; upper address bits are ignored and the address window is decoded upstream.

Reset
REQ-025 SHALL on i_nrst=0 set state=IDLE, all address/len/id registers=0, r_valid=b_valid=w_ready=0, aw_ready=ar_ready=0; memory contents are not cleared.
REQ-026 SHALL abort any in-progress burst on reset assertion with no further beats or responses. After reset release the first cycle is IDLE with aw_ready=1.

Verification
REQ-027 SHALL cover single write then read:
- stimulus: AW addr 0x10, len 0, size 3, id 5; W 0x1122334455667788, strb 0xFF, last.
- response: b_valid with OKAY, id 5.
- then AR same addr: r_valid at T+2 with r_data 0x1122334455667788, r_last=1, r_id 5.
REQ-028 SHALL cover INCR:
- stimulus: write len 3, size 3 at 0x100 with data 0xA0..0xA3; read back.
- response: 4 beats 0xA0..0xA3 (addresses 0x100,0x108,0x110,0x118); r_last only on the 4th beat.
REQ-029 SHALL cover WRAP:
- stimulus: read len 3, size 3 at 0x118 after REQ-028 contents.
- response: data order 0xA3,0xA0,0xA1,0xA2.
REQ-030 SHALL cover partial strobe:
- stimulus: word prefilled 0xFFFFFFFFFFFFFFFF; write 0x0 with strb 0x0F.
- response: read returns 0xFFFFFFFF00000000.
REQ-031 SHALL cover simultaneous AR and AW in IDLE:
- stimulus: ar_valid=aw_valid=1 in the same IDLE cycle.
- response: aw accepted first; ar_ready=0 until the b handshake, then AR accepted on the next IDLE cycle.
REQ-032 SHALL cover backpressure, length mismatch and reset:
- r_ready=0 for 5 cycles: r_valid/r_data held stable.
- w_last on beat 2 of a len 3 burst: b_resp=SLVERR.
- i_nrst pulse mid-read: r_valid=0 in the cycle of assertion.
